// File: rtl/clock_recovery.sv
// Recovers timing of an externally synchronized remote clock: edge events,
// half/full period measurement, lock qualification and stall detection.
package clks_alot_p;
  localparam int RATE_COUNTER_WIDTH = 8;

  typedef struct packed {
    logic rising_edge;
    logic falling_edge;
  } recovered_events_s;
endpackage

module clock_recovery #(
  parameter int RATE_COUNTER_WIDTH = clks_alot_p::RATE_COUNTER_WIDTH,
  parameter int LOCK_COUNT_WIDTH   = 4
) (
  input  logic                              clk,
  input  logic                              async_rst_n,
  input  logic                              clk_en,
  input  logic                              recovery_en_i,
  input  logic                              clear_state_i,
  input  logic                              sampled_clk_i,
  input  logic [RATE_COUNTER_WIDTH-1:0]     tolerance_i,
  input  logic [LOCK_COUNT_WIDTH-1:0]       lock_threshold_i,
  output clks_alot_p::recovered_events_s    recovered_events_o,
  output logic [RATE_COUNTER_WIDTH-1:0]     counter_current_o,
  output logic [RATE_COUNTER_WIDTH-1:0]     high_rate_o,
  output logic [RATE_COUNTER_WIDTH-1:0]     low_rate_o,
  output logic [RATE_COUNTER_WIDTH-1:0]     full_rate_o,
  output logic                              fully_locked_in_o,
  output logic                              lock_lost_violation_o,
  output logic                              stall_violation_o
);
  localparam logic [RATE_COUNTER_WIDTH-1:0] RATE_ZERO = {RATE_COUNTER_WIDTH{1'b0}};
  localparam logic [RATE_COUNTER_WIDTH-1:0] RATE_ONE  = {{(RATE_COUNTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RATE_COUNTER_WIDTH-1:0] RATE_MAX  = {RATE_COUNTER_WIDTH{1'b1}};
  localparam logic [LOCK_COUNT_WIDTH-1:0]   LOCK_ZERO = {LOCK_COUNT_WIDTH{1'b0}};
  localparam logic [LOCK_COUNT_WIDTH-1:0]   LOCK_ONE  = {{(LOCK_COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LOCK_COUNT_WIDTH-1:0]   LOCK_MAX  = {LOCK_COUNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t                          state_r, state_s;
  logic                            prev_level_r, prev_level_s;
  logic [RATE_COUNTER_WIDTH-1:0]   counter_r, counter_s;
  logic [RATE_COUNTER_WIDTH-1:0]   high_r, high_s, low_r, low_s, full_r, full_s;
  logic [LOCK_COUNT_WIDTH-1:0]     lock_cnt_r, lock_cnt_s, lock_inc_s;
  logic                            first_r, first_s, high_ok_r, high_ok_s;
  logic                            locked_r, locked_s, lost_r, lost_s, stall_r, stall_s;
  clks_alot_p::recovered_events_s  events_r, events_s;
  logic                            rise_s, fall_s, tol_ok_s, qualify_s;
  logic [RATE_COUNTER_WIDTH-1:0]   meas_s, held_s;

  function automatic logic in_tol(input logic [RATE_COUNTER_WIDTH-1:0] a,
                                  input logic [RATE_COUNTER_WIDTH-1:0] b,
                                  input logic [RATE_COUNTER_WIDTH-1:0] tol);
    logic [RATE_COUNTER_WIDTH-1:0] diff;
    if (a >= b) begin
      diff = a - b;
    end else begin
      diff = b - a;
    end
    return (diff <= tol);
  endfunction

  assign rise_s     = sampled_clk_i & ~prev_level_r;
  assign fall_s     = ~sampled_clk_i & prev_level_r;
  assign meas_s     = counter_r + RATE_ONE;
  assign held_s     = rise_s ? low_r : high_r;
  // The first measurement after entering MEASURE has no trustworthy reference.
  assign tol_ok_s   = ~first_r & in_tol(meas_s, held_s, tolerance_i);
  assign qualify_s  = rise_s & tol_ok_s & high_ok_r;
  assign lock_inc_s = (lock_cnt_r == LOCK_MAX) ? lock_cnt_r : lock_cnt_r + LOCK_ONE;

  // Next-state, measurement and pulse generation.
  always_comb begin
    state_s      = state_r;
    prev_level_s = prev_level_r;
    counter_s    = counter_r;
    high_s       = high_r;
    low_s        = low_r;
    full_s       = full_r;
    lock_cnt_s   = lock_cnt_r;
    first_s      = first_r;
    high_ok_s    = high_ok_r;
    locked_s     = locked_r;
    events_s     = 2'b00;
    lost_s       = 1'b0;
    stall_s      = 1'b0;
    if (clear_state_i) begin
      state_s      = IDLE;
      prev_level_s = clk_en ? sampled_clk_i : prev_level_r;
      counter_s    = RATE_ZERO;
      high_s       = RATE_ZERO;
      low_s        = RATE_ZERO;
      full_s       = RATE_ZERO;
      lock_cnt_s   = LOCK_ZERO;
      first_s      = 1'b0;
      high_ok_s    = 1'b0;
      locked_s     = 1'b0;
    end else if (clk_en) begin
      prev_level_s = sampled_clk_i;
      if (!recovery_en_i) begin
        state_s    = IDLE;
        counter_s  = RATE_ZERO;
        lock_cnt_s = LOCK_ZERO;
        locked_s   = 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            state_s   = SEEK;
            counter_s = RATE_ZERO;
          end
          SEEK: begin
            counter_s = (rise_s || fall_s) ? RATE_ZERO :
                        ((counter_r == RATE_MAX) ? counter_r : counter_r + RATE_ONE);
            if (rise_s) begin
              state_s    = MEASURE;
              first_s    = 1'b1;
              high_ok_s  = 1'b0;
              lock_cnt_s = LOCK_ZERO;
            end else begin
              state_s = SEEK;
            end
          end
          MEASURE, LOCKED: begin
            events_s.rising_edge  = rise_s;
            events_s.falling_edge = fall_s;
            if (rise_s || fall_s) begin
              counter_s = RATE_ZERO;
              first_s   = 1'b0;
              if (fall_s) begin
                high_s    = meas_s;
                high_ok_s = tol_ok_s;
              end else begin
                low_s      = meas_s;
                full_s     = high_r + meas_s;
                lock_cnt_s = qualify_s ? lock_inc_s : LOCK_ZERO;
              end
              if ((state_r == LOCKED) && !tol_ok_s) begin
                state_s    = MEASURE;
                lost_s     = 1'b1;
                locked_s   = 1'b0;
                lock_cnt_s = LOCK_ZERO;
                first_s    = 1'b1;
                high_ok_s  = 1'b0;
              end else if ((state_r == MEASURE) && qualify_s && (lock_inc_s >= lock_threshold_i)) begin
                state_s  = LOCKED;
                locked_s = 1'b1;
              end else begin
                state_s = state_r;
              end
            end else if (counter_r == RATE_MAX) begin
              // Counter held at all-ones; SEEK does not re-raise the stall.
              state_s    = SEEK;
              stall_s    = 1'b1;
              locked_s   = 1'b0;
              lock_cnt_s = LOCK_ZERO;
            end else begin
              counter_s = counter_r + RATE_ONE;
            end
          end
          default: begin
            state_s = IDLE;
          end
        endcase
      end
    end else begin
      prev_level_s = prev_level_r;
    end
  end

  // State register; pulses are strobes of one clk cycle even when clk_en is low.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_r      <= IDLE;
      prev_level_r <= 1'b0;
      counter_r    <= RATE_ZERO;
      high_r       <= RATE_ZERO;
      low_r        <= RATE_ZERO;
      full_r       <= RATE_ZERO;
      lock_cnt_r   <= LOCK_ZERO;
      first_r      <= 1'b0;
      high_ok_r    <= 1'b0;
      locked_r     <= 1'b0;
      events_r     <= 2'b00;
      lost_r       <= 1'b0;
      stall_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      prev_level_r <= prev_level_s;
      counter_r    <= counter_s;
      high_r       <= high_s;
      low_r        <= low_s;
      full_r       <= full_s;
      lock_cnt_r   <= lock_cnt_s;
      first_r      <= first_s;
      high_ok_r    <= high_ok_s;
      locked_r     <= locked_s;
      events_r     <= events_s;
      lost_r       <= lost_s;
      stall_r      <= stall_s;
    end
  end

  assign recovered_events_o    = events_r;
  assign counter_current_o     = counter_r;
  assign high_rate_o           = high_r;
  assign low_rate_o            = low_r;
  assign full_rate_o           = full_r;
  assign fully_locked_in_o     = locked_r;
  assign lock_lost_violation_o = lost_r;
  assign stall_violation_o     = stall_r;
endmodule

// File: tb/tb_clock_recovery.sv
// Scoreboard bench for clock_recovery: stimulus queues hand-computed records,
// a negedge monitor pops one per observed pulse and compares.
module tb_clock_recovery;
  localparam int RW = 8;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic async_rst_n, clk_en, recovery_en_i, clear_state_i, sampled_clk_i;
  logic [RW-1:0] tolerance_i;
  logic [LW-1:0] lock_threshold_i;
  clks_alot_p::recovered_events_s recovered_events_o;
  logic [RW-1:0] counter_current_o, high_rate_o, low_rate_o, full_rate_o;
  logic fully_locked_in_o, lock_lost_violation_o, stall_violation_o;

  typedef struct {
    string         tag;
    logic          rise, fall, stall, lost, locked;
    logic [RW-1:0] h, l, f;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  bit   toggle_en = 1'b0;

  always #5 clk = ~clk;

  clock_recovery #(.RATE_COUNTER_WIDTH(RW), .LOCK_COUNT_WIDTH(LW)) dut (
    .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
    .recovery_en_i(recovery_en_i), .clear_state_i(clear_state_i),
    .sampled_clk_i(sampled_clk_i), .tolerance_i(tolerance_i),
    .lock_threshold_i(lock_threshold_i), .recovered_events_o(recovered_events_o),
    .counter_current_o(counter_current_o), .high_rate_o(high_rate_o),
    .low_rate_o(low_rate_o), .full_rate_o(full_rate_o),
    .fully_locked_in_o(fully_locked_in_o), .lock_lost_violation_o(lock_lost_violation_o),
    .stall_violation_o(stall_violation_o));

  function automatic exp_t mk(input string tag, input logic rise, input logic fall,
                              input logic stall, input logic lost, input logic locked,
                              input logic [RW-1:0] h, input logic [RW-1:0] l,
                              input logic [RW-1:0] f);
    exp_t e;
    e.tag = tag; e.rise = rise; e.fall = fall; e.stall = stall; e.lost = lost;
    e.locked = locked; e.h = h; e.l = l; e.f = f;
    return e;
  endfunction

  function automatic logic [63:0] outs();
    return {27'd0, recovered_events_o, counter_current_o, high_rate_o, low_rate_o,
            full_rate_o, fully_locked_in_o, lock_lost_violation_o, stall_violation_o};
  endfunction

  // Monitor: every output pulse must match the oldest queued record.
  always @(negedge clk) begin
    if (async_rst_n && (recovered_events_o.rising_edge || recovered_events_o.falling_edge ||
                        stall_violation_o || lock_lost_violation_o)) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_pulse: got rise=%0b fall=%0b stall=%0b lost=%0b, required none",
                 recovered_events_o.rising_edge, recovered_events_o.falling_edge,
                 stall_violation_o, lock_lost_violation_o);
      end else begin
        mon_e = exp_q.pop_front();
        if ({recovered_events_o.rising_edge, recovered_events_o.falling_edge, stall_violation_o,
             lock_lost_violation_o, fully_locked_in_o, high_rate_o, low_rate_o, full_rate_o} !==
            {mon_e.rise, mon_e.fall, mon_e.stall, mon_e.lost, mon_e.locked, mon_e.h, mon_e.l, mon_e.f}) begin
          bad = bad + 1;
          $display("FAIL %s: got r=%0b f=%0b s=%0b lost=%0b lock=%0b h=%0d l=%0d full=%0d, required r=%0b f=%0b s=%0b lost=%0b lock=%0b h=%0d l=%0d full=%0d",
                   mon_e.tag, recovered_events_o.rising_edge, recovered_events_o.falling_edge,
                   stall_violation_o, lock_lost_violation_o, fully_locked_in_o, high_rate_o,
                   low_rate_o, full_rate_o, mon_e.rise, mon_e.fall, mon_e.stall, mon_e.lost,
                   mon_e.locked, mon_e.h, mon_e.l, mon_e.f);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic step();
    clk_en = 1'b1;
    @(posedge clk); #1;
    if (toggle_en) begin
      clk_en = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_half(input logic lvl, input int n);
    sampled_clk_i = lvl;
    repeat (n) step();
  endtask

  task automatic half_ev(input logic lvl, input int n, input string tag, input logic lost,
                         input logic locked, input logic [RW-1:0] h, input logic [RW-1:0] l,
                         input logic [RW-1:0] f);
    exp_q.push_back(mk(tag, lvl, ~lvl, 1'b0, lost, locked, h, l, f));
    drive_half(lvl, n);
  endtask

  // Low 6, then n periods of high 4 / low 6; the first rise is the SEEK->MEASURE edge.
  task automatic periods(input int n, input int lock_from, input string tag);
    drive_half(1'b0, 6);
    for (int i = 0; i < n; i++) begin
      if (i > 0) exp_q.push_back(mk({tag, "_rise"}, 1'b1, 1'b0, 1'b0, 1'b0, i >= lock_from,
                                    8'd4, 8'd6, 8'd10));
      drive_half(1'b1, 4);
      exp_q.push_back(mk({tag, "_fall"}, 1'b0, 1'b1, 1'b0, 1'b0, i >= lock_from, 8'd4,
                         (i == 0) ? 8'd0 : 8'd6, (i == 0) ? 8'd0 : 8'd10));
      drive_half(1'b0, 6);
    end
  endtask

  initial begin
    async_rst_n = 1'b0; clk_en = 1'b0; recovery_en_i = 1'b0; clear_state_i = 1'b0;
    sampled_clk_i = 1'b0; tolerance_i = 8'd0; lock_threshold_i = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 64'd0);
    async_rst_n = 1'b1;
    recovery_en_i = 1'b1;

    // Stable 4/6, tolerance 0, threshold 3: locks on the 4th rise after the first.
    periods(6, 4, "stable");
    check("stable_locked", {63'd0, fully_locked_in_o}, 64'd1);

    // Stretched low phase while locked, tolerance 1.
    tolerance_i = 8'd1;
    half_ev(1'b1, 4, "pre_rise",     1'b0, 1'b1, 8'd4, 8'd6, 8'd10);
    half_ev(1'b0, 8, "pre_fall",     1'b0, 1'b1, 8'd4, 8'd6, 8'd10);
    half_ev(1'b1, 4, "lost_rise",    1'b1, 1'b0, 8'd4, 8'd8, 8'd12);
    half_ev(1'b0, 6, "lost_fall",    1'b0, 1'b0, 8'd4, 8'd8, 8'd12);
    half_ev(1'b1, 4, "relock_r0",    1'b0, 1'b0, 8'd4, 8'd6, 8'd10);
    half_ev(1'b0, 6, "relock_f0",    1'b0, 1'b0, 8'd4, 8'd6, 8'd10);
    half_ev(1'b1, 4, "relock_r1",    1'b0, 1'b0, 8'd4, 8'd6, 8'd10);
    half_ev(1'b0, 6, "relock_f1",    1'b0, 1'b0, 8'd4, 8'd6, 8'd10);
    half_ev(1'b1, 4, "relock_r2",    1'b0, 1'b0, 8'd4, 8'd6, 8'd10);
    half_ev(1'b0, 6, "relock_f2",    1'b0, 1'b0, 8'd4, 8'd6, 8'd10);
    half_ev(1'b1, 4, "relock_r3",    1'b0, 1'b1, 8'd4, 8'd6, 8'd10);
    half_ev(1'b0, 6, "relock_f3",    1'b0, 1'b1, 8'd4, 8'd6, 8'd10);

    // Asynchronous reset between clock edges while locked.
    check("locked_before_reset", {63'd0, fully_locked_in_o}, 64'd1);
    #2;
    async_rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs(), 64'd0);
    @(posedge clk); #1;
    async_rst_n = 1'b1;

    // Same clock expressed in enabled cycles with clk_en toggling.
    tolerance_i = 8'd0;
    toggle_en = 1'b1;
    periods(6, 4, "gated");
    toggle_en = 1'b0;
    check("gated_rates", {40'd0, high_rate_o, low_rate_o, full_rate_o}, {40'd0, 8'd4, 8'd6, 8'd10});

    // Stuck high while locked: one stall pulse at counter 255, then SEEK.
    exp_q.push_back(mk("stuck_rise", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 8'd6, 8'd10));
    exp_q.push_back(mk("stall", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 8'd6, 8'd10));
    drive_half(1'b1, 300);
    check("stall_counter", {56'd0, counter_current_o}, 64'd255);
    check("stall_unlocked", {63'd0, fully_locked_in_o}, 64'd0);
    drive_half(1'b0, 6);
    drive_half(1'b1, 4);
    half_ev(1'b0, 6, "reseek_fall", 1'b0, 1'b0, 8'd4, 8'd6, 8'd10);

    // Synchronous clear in MEASURE, then threshold 0 locks on the first qualifying rise.
    clear_state_i = 1'b1;
    @(posedge clk); #1;
    clear_state_i = 1'b0;
    check("clear_outputs", outs(), 64'd0);
    step();
    check("clear_idle_counter", {56'd0, counter_current_o}, 64'd0);
    lock_threshold_i = 4'd0;
    periods(3, 2, "thresh0");
    check("thresh0_locked", {63'd0, fully_locked_in_o}, 64'd1);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
